pipelined_barrel_shifter: RTL and testbench
===========================================

PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; SHALL be a power of two, 4 to 64.
REQ-002 Parameter SHW, default 4, shift-amount width; SHALL equal log2(WIDTH) and also sets the number of pipeline stages.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 Reset  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  input transfer request.
REQ-006 in_ready  output  1  block can accept an input this cycle.
REQ-007 a  input  WIDTH  operand.
REQ-008 shift_width  input  SHW  shift amount, 0 to WIDTH-1.
REQ-009 mode  input  2  operation select: 00 SLL (logical left), 01 SRL (logical right), 10 SRA (arithmetic right), 11 ROL (rotate left).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 shifted_a  output  WIDTH  result.
REQ-013 OV  output  1  overflow flag, accompanies shifted_a.
REQ-014 out_count  output  16  count of completed output transfers.

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1. Output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Datapath SHALL be a logarithmic shifter of SHW registered stages. Stage k SHALL conditionally apply a shift of 2^k for bit k of shift_width.
REQ-017 Each stage SHALL carry the following alongside data: valid bit, mode, remaining shift bits, and the accumulated OV.
REQ-018 Latency SHALL be SHW cycles: a transfer accepted at edge t SHALL present out_valid=1 with its result after edge t+SHW-1 (WIDTH=16: accepted at edge 1, visible after edge 4).
REQ-019 Throughput SHALL be one transfer per cycle when out_ready=1 continuously.
REQ-020 Stall: when out_valid=1 and out_ready=0, every stage SHALL hold its contents and in_ready SHALL be 0.
REQ-021 Otherwise in_ready SHALL be 1, including when the pipeline is full and the output transfers in the same cycle.
REQ-022 Bubbles (valid=0 stages) SHALL advance normally and SHALL NOT be collapsed.
REQ-023 When in_valid=0 at an accept opportunity, stage 0 SHALL load valid=0.
REQ-024 SLL and SRL SHALL fill vacated bits with 0.
REQ-025 SRA SHALL fill vacated bits with a[WIDTH-1].
REQ-026 ROL SHALL reinsert bits shifted out of the MSB at the LSB.
REQ-027 shift_width=0 SHALL pass a unchanged in all modes.
REQ-028 In SLL mode, OV SHALL be 1 if any 1 bit was shifted out past the MSB; in all other modes OV SHALL be 0.
REQ-029 out_count SHALL increment by 1 on each output transfer and SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 Stages holding valid=0 SHALL NOT affect out_count or any output handshake.
REQ-031 Input accept and output transfer in the same cycle SHALL both complete, with no loss, duplication or reordering.

Reset
REQ-032 While Reset=0 at a rising edge, all stage valid bits SHALL clear and all in-flight transfers SHALL be discarded.
REQ-033 Reset values: out_valid=0, shifted_a=0, OV=0, out_count=16'h0000.
REQ-034 in_ready SHALL be 0 while Reset=0 and 1 in the first cycle after release.
REQ-035 Reset asserted mid-stream SHALL take effect at the next rising edge; no result accepted before reset SHALL appear after release.

Verification
REQ-036 SLL, a=16'h00FF, sh=4 -> shifted_a=16'h0FF0, OV=0, out_valid 4 cycles after accept.
REQ-037 SLL, a=16'hF001, sh=4 -> 16'h0010, OV=1.
REQ-038 a=16'h8000, sh=15: SRA -> 16'hFFFF, SRL -> 16'h0001; ROL a=16'h8001, sh=1 -> 16'h0003; any mode with sh=0 -> a, OV=0.
REQ-039 Back-to-back stream of 8 operands (a=0..7, sh=1, SLL) with out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs 0,2,...,14 in order with none lost or duplicated, out_count=8.
REQ-040 Reset=0 for one edge with 3 transfers in flight -> out_valid=0 and out_count=0 next cycle, no stale results after release, first new operand emerges after 4 cycles.
REQ-041 Exhaustive sweep driven by a free-running 16-bit counter over a[7:0], shift_width and mode, with WIDTH=8, SHW=3 -> every result and OV match a behavioural reference model, including the out_count wrap at 16'hFFFF.

Source files
------------

// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter: operand side in, result side out.
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shift_width;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] shifted_a;
  logic             OV;
  logic [15:0]      out_count;

  modport master (
    output in_valid, a, shift_width, mode, out_ready,
    input  in_ready, out_valid, shifted_a, OV, out_count
  );

  modport slave (
    input  in_valid, a, shift_width, mode, out_ready,
    output in_ready, out_valid, shifted_a, OV, out_count
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log shifter with SHW registered stages (stage k applies 2^k); whole pipe freezes
// while the last stage holds a result the consumer refuses.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  pipelined_barrel_shifter_if.slave   bus
);
  // Remaining shift bits shrink by one per stage; packed triangularly.
  localparam int RB = SHW * (SHW - 1) / 2;

  logic [SHW-1:0]            r_vld_pipe;
  logic [SHW-1:0][WIDTH-1:0] r_data;
  logic [SHW-1:0]            r_ov;
  logic [SHW-2:0][1:0]       r_mode;
  logic [RB-1:0]             r_rem;
  logic [15:0]               r_out_count;

  logic [SHW-1:0]            w_vld_nxt;
  logic [SHW-1:0][WIDTH-1:0] w_data_nxt;
  logic [SHW-1:0]            w_ov_nxt;
  logic [SHW-2:0][1:0]       w_mode_nxt;
  logic [RB-1:0]             w_rem_nxt;
  logic                      w_stall;

  assign w_stall   = r_vld_pipe[SHW-1] & ~bus.out_ready;
  assign w_vld_nxt = {r_vld_pipe[SHW-2:0], bus.in_valid};

  for (genvar k = 0; k < SHW; k++) begin : g_st
    localparam int AMT = 1 << k;
    logic [WIDTH-1:0] w_din, w_dout;
    logic [1:0]       w_mode;
    logic [SHW-1-k:0] w_rem;
    logic             w_ovin, w_ovout;

    if (k == 0) begin : g_src
      assign w_din  = bus.a;
      assign w_mode = bus.mode;
      assign w_rem  = bus.shift_width;
      assign w_ovin = 1'b0;
    end else begin : g_src
      localparam int OFFP = (k - 1) * (SHW - 1) - (k - 1) * (k - 2) / 2;
      assign w_din  = r_data[k-1];
      assign w_mode = r_mode[k-1];
      assign w_rem  = r_rem[OFFP +: SHW-k];
      assign w_ovin = r_ov[k-1];
    end

    always_comb begin
      w_dout  = w_din;
      w_ovout = w_ovin;
      if (w_rem[0]) begin
        unique case (w_mode)
          2'b00: begin
            w_dout  = w_din << AMT;
            w_ovout = w_ovin | (|w_din[WIDTH-1 -: AMT]);
          end
          2'b01:   w_dout = w_din >> AMT;
          2'b10:   w_dout = WIDTH'($signed(w_din) >>> AMT);
          default: w_dout = (w_din << AMT) | (w_din >> (WIDTH - AMT));
        endcase
      end
    end

    assign w_data_nxt[k] = w_dout;
    assign w_ov_nxt[k]   = w_ovout;

    if (k < SHW - 1) begin : g_fwd
      localparam int OFF = k * (SHW - 1) - k * (k - 1) / 2;
      assign w_mode_nxt[k]              = w_mode;
      assign w_rem_nxt[OFF +: SHW-1-k]  = w_rem[SHW-1-k:1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
      r_ov       <= '0;
      r_mode     <= '0;
      r_rem      <= '0;
    end else if (!w_stall) begin
      r_vld_pipe <= w_vld_nxt;
      r_data     <= w_data_nxt;
      r_ov       <= w_ov_nxt;
      r_mode     <= w_mode_nxt;
      r_rem      <= w_rem_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                              r_out_count <= '0;
    else if (r_vld_pipe[SHW-1] && bus.out_ready) r_out_count <= r_out_count + 16'd1;
  end

  assign bus.in_ready  = i_rst_n & ~w_stall;
  assign bus.out_valid = r_vld_pipe[SHW-1];
  assign bus.shifted_a = r_data[SHW-1];
  assign bus.OV        = r_ov[SHW-1];
  assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed checks on a 16-bit instance plus a counter-driven sweep on an 8-bit one.
module tb_pipelined_barrel_shifter;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROL = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst16_n, rst8_n;

  pipelined_barrel_shifter_if #(.WIDTH(16), .SHW(4)) b16 ();
  pipelined_barrel_shifter_if #(.WIDTH(8),  .SHW(3)) b8 ();

  pipelined_barrel_shifter #(.WIDTH(16), .SHW(4)) dut16 (.i_clk(clk), .i_rst_n(rst16_n), .bus(b16));
  pipelined_barrel_shifter #(.WIDTH(8),  .SHW(3)) dut8  (.i_clk(clk), .i_rst_n(rst8_n),  .bus(b8));

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bitwise reference: {ov, result}
  function automatic logic [64:0] ref_op(input logic [63:0] a, input int sh, input logic [1:0] m, input int w);
    logic [63:0] r;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    for (int i = 0; i < w; i++) begin
      case (m)
        SLL:     r[i] = (i >= sh)   ? a[i-sh] : 1'b0;
        SRL:     r[i] = (i + sh < w) ? a[i+sh] : 1'b0;
        SRA:     r[i] = (i + sh < w) ? a[i+sh] : a[w-1];
        default: r[i] = a[(i - sh + w) % w];
      endcase
    end
    if (m == SLL)
      for (int j = w - sh; j < w; j++) ov = ov | a[j];
    return {ov, r};
  endfunction

  task automatic send_one(input string tag, input logic [15:0] a, input logic [3:0] sh,
                          input logic [1:0] m, input logic [15:0] ed, input logic eo);
    int n;
    @(negedge clk);
    b16.a = a; b16.shift_width = sh; b16.mode = m; b16.in_valid = 1'b1; b16.out_ready = 1'b1;
    #1 chk({tag, "_rdy"}, b16.in_ready, 1);
    @(negedge clk);
    b16.in_valid = 1'b0;
    n = 1;
    while (!b16.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_d"}, b16.shifted_a, ed);
    chk({tag, "_ov"}, b16.OV, eo);
  endtask

  initial begin
    int idx, got, n_out;
    logic [15:0] cnt;
    logic [64:0] r;
    logic [8:0]  e;
    logic [8:0]  q[$];

    b16.in_valid = 0; b16.a = '0; b16.shift_width = '0; b16.mode = '0; b16.out_ready = 1;
    b8.in_valid  = 0; b8.a  = '0; b8.shift_width  = '0; b8.mode  = '0; b8.out_ready  = 1;
    rst16_n = 0; rst8_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_vld", b16.out_valid, 0);
    chk("rst_dat", b16.shifted_a, 0);
    chk("rst_ov",  b16.OV, 0);
    chk("rst_cnt", b16.out_count, 0);
    chk("rst_rdy", b16.in_ready, 0);
    rst16_n = 1;
    #1 chk("rel_rdy", b16.in_ready, 1);

    send_one("sll_00ff", 16'h00FF, 4'd4,  SLL, 16'h0FF0, 1'b0);
    send_one("sll_f001", 16'hF001, 4'd4,  SLL, 16'h0010, 1'b1);
    send_one("sra_8000", 16'h8000, 4'd15, SRA, 16'hFFFF, 1'b0);
    send_one("srl_8000", 16'h8000, 4'd15, SRL, 16'h0001, 1'b0);
    send_one("rol_8001", 16'h8001, 4'd1,  ROL, 16'h0003, 1'b0);
    send_one("sh0_sll",  16'hA5C3, 4'd0,  SLL, 16'hA5C3, 1'b0);
    send_one("sh0_srl",  16'hA5C3, 4'd0,  SRL, 16'hA5C3, 1'b0);
    send_one("sh0_sra",  16'hA5C3, 4'd0,  SRA, 16'hA5C3, 1'b0);
    send_one("sh0_rol",  16'hA5C3, 4'd0,  ROL, 16'hA5C3, 1'b0);
    send_one("sll_msb",  16'h8000, 4'd1,  SLL, 16'h0000, 1'b1);
    send_one("sra_pos",  16'h7000, 4'd3,  SRA, 16'h0E00, 1'b0);
    @(negedge clk);
    chk("dir_cnt", b16.out_count, 11);
    chk("dir_idle", b16.out_valid, 0);

    // Back-to-back stream with a 3-cycle consumer stall
    rst16_n = 0;
    @(negedge clk);
    rst16_n = 1;
    idx = 0; got = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      b16.out_ready = !(c >= 5 && c <= 7);
      b16.in_valid = (idx < 8);
      b16.a = 16'(idx); b16.shift_width = 4'd1; b16.mode = SLL;
      #1;
      chk("stall_rdy", b16.in_ready, (c >= 5 && c <= 7) ? 0 : 1);
      if (b16.out_valid && b16.out_ready) begin
        chk("strm", b16.shifted_a, 2 * got);
        got++;
      end
      if (b16.in_valid && b16.in_ready) idx++;
    end
    chk("strm_n", got, 8);
    @(negedge clk);
    b16.in_valid = 0; b16.out_ready = 1;
    chk("strm_cnt", b16.out_count, 8);
    repeat (3) begin
      @(negedge clk);
      chk("strm_dup", b16.out_valid, 0);
    end

    // Reset with three transfers in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b16.in_valid = 1; b16.a = 16'h0100 + 16'(i); b16.shift_width = '0; b16.mode = SLL;
    end
    @(negedge clk);
    b16.in_valid = 0; rst16_n = 0;
    #1 chk("mid_rdy", b16.in_ready, 0);
    @(negedge clk);
    rst16_n = 1;
    chk("mid_vld", b16.out_valid, 0);
    chk("mid_cnt", b16.out_count, 0);
    repeat (6) begin
      @(negedge clk);
      chk("stale", b16.out_valid, 0);
    end
    send_one("post_rst", 16'h1234, 4'd4, ROL, 16'h2341, 1'b0);

    // Counter-driven sweep on the 8-bit instance, running past the out_count wrap
    @(negedge clk);
    rst8_n = 1;
    cnt = '0; n_out = 0;
    for (int c = 0; c < 70000 && n_out < 65539; c++) begin
      @(negedge clk);
      if (n_out == 65535) chk("cnt_ffff", b8.out_count, 16'hFFFF);
      if (n_out == 65536) chk("cnt_wrap", b8.out_count, 0);
      b8.in_valid = 1; b8.a = cnt[7:0]; b8.shift_width = cnt[10:8]; b8.mode = cnt[12:11];
      b8.out_ready = 1;
      #1;
      if (b8.out_valid) begin
        if (q.size() == 0) chk("sw_extra", 1, 0);
        else begin
          e = q.pop_front();
          chk("sw_d", b8.shifted_a, e[7:0]);
          chk("sw_ov", b8.OV, e[8]);
        end
        n_out++;
      end
      if (b8.in_ready) begin
        r = ref_op({56'd0, cnt[7:0]}, int'(cnt[10:8]), cnt[12:11], 8);
        q.push_back({r[64], r[7:0]});
        cnt++;
      end
    end
    chk("sw_n", n_out, 65539);
    @(negedge clk);
    chk("sw_cnt", b8.out_count, 3);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
